mc_ctrl: RTL and testbench

//  Multi-cycle sequencer for the MIPS-lite datapath: ADDU SUBU SLT JR ORI LUI LW SW ADDI ADDIU BEQ J JAL.

---
 rtl/mc_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-lite sequencer sharing one ALU and one memory port.
// Define MC_CTRL_PERF_EN to add the cyc_cnt / ret_cnt performance counters.
module mc_ctrl #(
  parameter int MAX_WAIT = 16
`ifdef MC_CTRL_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PcWrite,
  output logic       IrWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [2:0] NpcSel,
  output logic [1:0] RegDst,
  output logic [1:0] wd_sel,
  output logic [1:0] ExtOp,
  output logic       AluSrc,
  output logic [3:0] AluCtrl,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL   = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_ORI = 6'h0d, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23, OP_SW  = 6'h2b;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_SLT = 6'h2a;

  localparam logic [3:0] ALU_ADDU = 4'd0, ALU_SUBU = 4'd1, ALU_OR = 4'd2, ALU_BB = 4'd3;
  localparam logic [3:0] ALU_AA   = 4'd4, ALU_ADD  = 4'd5, ALU_LT = 4'd6;
  localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_LUI = 2'd2;
  localparam logic [2:0] NPC_PC4 = 3'd0, NPC_BR = 3'd1, NPC_JAL = 3'd2, NPC_J = 3'd3, NPC_JR = 3'd4;
  localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
  localparam logic [1:0] WD_ALU = 2'd0, WD_MEM = 2'd1, WD_PC = 2'd2;

  // Counter only needs to reach MAX_WAIT-1: expiry fires on the MAX_WAIT-th idle cycle.
  localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DCD = 4'd1, S_EXE = 4'd2, S_AWB = 4'd3,
    S_MA    = 4'd4, S_MRD = 4'd5, S_MWB = 4'd6, S_MWR = 4'd7,
    S_BR    = 4'd8, S_JMP = 4'd9, S_JAL = 4'd10, S_JR = 4'd11
  } state_t;

  state_t            state_reg, state_next, dcd_next;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              wait_state, expire, is_rtype;
  logic [3:0]        exe_alu;
  logic              exe_src;
  logic [1:0]        exe_ext;

  assign is_rtype   = (opcode == OP_RTYPE);
  assign wait_state = (state_reg == S_FETCH) || (state_reg == S_MRD) || (state_reg == S_MWR);
  assign expire     = (MAX_WAIT > 0) && wait_state && !mem_ready &&
                      (wait_cnt_reg == WAIT_W'(MAX_WAIT - 1));

  // Instruction decode: successor of DCD plus the ALU setup used in EXE/AWB.
  always_comb begin
    dcd_next = S_FETCH;
    exe_alu  = ALU_ADDU;
    exe_src  = 1'b0;
    exe_ext  = EXT_ZERO;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin dcd_next = S_EXE; exe_alu = ALU_ADDU; end
          FN_SUBU: begin dcd_next = S_EXE; exe_alu = ALU_SUBU; end
          FN_SLT:  begin dcd_next = S_EXE; exe_alu = ALU_LT;   end
          FN_JR:   dcd_next = S_JR;
          default: dcd_next = S_FETCH;
        endcase
      end
      OP_ORI:   begin dcd_next = S_EXE; exe_alu = ALU_OR;   exe_src = 1'b1; exe_ext = EXT_ZERO; end
      OP_LUI:   begin dcd_next = S_EXE; exe_alu = ALU_BB;   exe_src = 1'b1; exe_ext = EXT_LUI;  end
      OP_ADDI:  begin dcd_next = S_EXE; exe_alu = ALU_ADD;  exe_src = 1'b1; exe_ext = EXT_SIGN; end
      OP_ADDIU: begin dcd_next = S_EXE; exe_alu = ALU_ADDU; exe_src = 1'b1; exe_ext = EXT_SIGN; end
      OP_LW, OP_SW: dcd_next = S_MA;
      OP_BEQ:   dcd_next = S_BR;
      OP_J:     dcd_next = S_JMP;
      OP_JAL:   dcd_next = S_JAL;
      default:  dcd_next = S_FETCH;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    PcWrite    = 1'b0;
    IrWrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    NpcSel     = NPC_PC4;
    RegDst     = DST_RT;
    wd_sel     = WD_ALU;
    ExtOp      = EXT_ZERO;
    AluSrc     = 1'b0;
    AluCtrl    = ALU_ADDU;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IrWrite    = 1'b1;
          PcWrite    = 1'b1;
          state_next = S_DCD;
        end else if (expire) begin
          bus_err = 1'b1;
        end
      end
      S_DCD: begin
        state_next = dcd_next;
        illegal    = (dcd_next == S_FETCH);
      end
      S_EXE: begin
        AluCtrl    = exe_alu;
        AluSrc     = exe_src;
        ExtOp      = exe_ext;
        state_next = S_AWB;
      end
      S_AWB: begin
        AluCtrl    = exe_alu;
        AluSrc     = exe_src;
        ExtOp      = exe_ext;
        RegWrite   = 1'b1;
        RegDst     = is_rtype ? DST_RD : DST_RT;
        state_next = S_FETCH;
      end
      S_MA: begin
        AluSrc     = 1'b1;
        ExtOp      = EXT_SIGN;
        state_next = (opcode == OP_LW) ? S_MRD : S_MWR;
      end
      S_MRD: begin
        MemRead = 1'b1;
        AluSrc  = 1'b1;
        ExtOp   = EXT_SIGN;
        if (mem_ready) begin
          state_next = S_MWB;
        end else if (expire) begin
          bus_err    = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_MWB: begin
        RegWrite   = 1'b1;
        wd_sel     = WD_MEM;
        state_next = S_FETCH;
      end
      S_MWR: begin
        MemWrite = 1'b1;
        AluSrc   = 1'b1;
        ExtOp    = EXT_SIGN;
        if (mem_ready) begin
          state_next = S_FETCH;
        end else if (expire) begin
          bus_err    = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_BR: begin
        AluCtrl    = ALU_SUBU;
        PcWrite    = zero;
        NpcSel     = NPC_BR;
        state_next = S_FETCH;
      end
      S_JMP: begin
        PcWrite    = 1'b1;
        NpcSel     = NPC_J;
        state_next = S_FETCH;
      end
      S_JAL: begin
        PcWrite    = 1'b1;
        NpcSel     = NPC_JAL;
        RegWrite   = 1'b1;
        RegDst     = DST_RA;
        wd_sel     = WD_PC;
        state_next = S_FETCH;
      end
      S_JR: begin
        AluCtrl    = ALU_AA;
        PcWrite    = 1'b1;
        NpcSel     = NPC_JR;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
    state = state_reg;
    // Reset silences every output in the same cycle so an aborted instruction writes nothing.
    if (reset) begin
      PcWrite  = 1'b0;
      IrWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      NpcSel   = NPC_PC4;
      RegDst   = DST_RT;
      wd_sel   = WD_ALU;
      ExtOp    = EXT_ZERO;
      AluSrc   = 1'b0;
      AluCtrl  = ALU_ADDU;
      illegal  = 1'b0;
      bus_err  = 1'b0;
      state    = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_FETCH;
      wait_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (!wait_state || mem_ready || expire || (state_next != state_reg)) begin
        wait_cnt_reg <= '0;
      end else begin
        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
      end
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] cyc_cnt_reg, ret_cnt_reg;
  logic             retire;

  // A bus error out of MWR also lands in FETCH but is not a retirement.
  assign retire = (state_next == S_FETCH) && !expire &&
                  (state_reg inside {S_AWB, S_MWB, S_MWR, S_BR, S_JMP, S_JAL, S_JR});

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt_reg <= '0;
      ret_cnt_reg <= '0;
    end else begin
      cyc_cnt_reg <= cyc_cnt_reg + CNT_W'(1);
      if (retire) begin
        ret_cnt_reg <= ret_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign cyc_cnt = cyc_cnt_reg;
  assign ret_cnt = ret_cnt_reg;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: random instruction stream against a per-instruction phase model of mc_ctrl.
// Each transaction is expanded into an expected cycle trace (state, strobes, fields).
module tb_mc_ctrl;

  localparam int MAX_WAIT = 4;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DCD = 4'd1, ST_EXE = 4'd2, ST_AWB = 4'd3;
  localparam logic [3:0] ST_MA = 4'd4, ST_MRD = 4'd5, ST_MWB = 4'd6, ST_MWR = 4'd7;
  localparam logic [3:0] ST_BR = 4'd8, ST_JMP = 4'd9, ST_JAL = 4'd10, ST_JR = 4'd11;

  localparam int K_ADDU = 0, K_SUBU = 1, K_SLT = 2, K_JR = 3, K_ORI = 4, K_LUI = 5, K_LW = 6;
  localparam int K_SW = 7, K_ADDI = 8, K_ADDIU = 9, K_BEQ = 10, K_J = 11, K_JAL = 12;
  localparam int K_ILLOP = 13, K_ILLFN = 14;

  typedef struct packed {
    logic [3:0]  st;
    logic        rdy;
    logic [20:0] o;
  } cyc_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       PcWrite, IrWrite, MemRead, MemWrite, RegWrite, AluSrc, illegal, bus_err;
  logic [2:0] NpcSel;
  logic [1:0] RegDst, wd_sel, ExtOp;
  logic [3:0] AluCtrl, state;
  logic [20:0] outs;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
  int          exp_cyc_total = 0;
  int          exp_ret_total = 0;
`endif

  int   err_cnt = 0;
  int   chk_cnt = 0;
  int   txn_cnt = 0;
  int   exp_ret;
  cyc_t exp_q[$];
  string kname [0:14] = '{"ADDU", "SUBU", "SLT", "JR", "ORI", "LUI", "LW", "SW",
                          "ADDI", "ADDIU", "BEQ", "J", "JAL", "ILLOP", "ILLFN"};

  mc_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PcWrite(PcWrite), .IrWrite(IrWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .NpcSel(NpcSel), .RegDst(RegDst),
    .wd_sel(wd_sel), .ExtOp(ExtOp), .AluSrc(AluSrc), .AluCtrl(AluCtrl),
    .illegal(illegal), .bus_err(bus_err), .state(state)
`ifdef MC_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign outs = {PcWrite, IrWrite, MemRead, MemWrite, RegWrite, NpcSel, RegDst,
                 wd_sel, ExtOp, AluSrc, AluCtrl, illegal, bus_err};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [20:0] mk(input int pcw, input int irw, input int mrd, input int mwr,
                                     input int rgw, input int npc, input int rdst, input int wds,
                                     input int ext, input int src, input int alu, input int ill,
                                     input int berr);
    return {1'(pcw), 1'(irw), 1'(mrd), 1'(mwr), 1'(rgw), 3'(npc), 2'(rdst), 2'(wds),
            2'(ext), 1'(src), 4'(alu), 1'(ill), 1'(berr)};
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic [3:0] st, input logic rdy, input logic [20:0] o);
    cyc_t c;
    c.st = st;
    c.rdy = rdy;
    c.o = o;
    exp_q.push_back(c);
  endfunction

  // Memory phase: 'waits' idle cycles then ready; abandoned on the MAX_WAIT-th idle cycle.
  function automatic bit push_mem(input logic [3:0] st, input int waits,
                                  input logic [20:0] busy, input logic [20:0] done);
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        push(st, 1'b1, done);
        return 1'b1;
      end
      if (MAX_WAIT > 0 && i == MAX_WAIT - 1) begin
        push(st, 1'b0, busy | 21'd1);
        return 1'b0;
      end
      push(st, 1'b0, busy);
    end
    return 1'b0;
  endfunction

  function automatic logic [11:0] enc(input int kind);
    logic [5:0] rf;
    rf = 6'($urandom);
    case (kind)
      K_ADDU:  return {6'h00, 6'h21};
      K_SUBU:  return {6'h00, 6'h23};
      K_SLT:   return {6'h00, 6'h2a};
      K_JR:    return {6'h00, 6'h08};
      K_ORI:   return {6'h0d, rf};
      K_LUI:   return {6'h0f, rf};
      K_LW:    return {6'h23, rf};
      K_SW:    return {6'h2b, rf};
      K_ADDI:  return {6'h08, rf};
      K_ADDIU: return {6'h09, rf};
      K_BEQ:   return {6'h04, rf};
      K_J:     return {6'h02, rf};
      K_JAL:   return {6'h03, rf};
      K_ILLOP: return {6'h3f, rf};
      default: begin
        case ($urandom_range(0, 2))
          0:       return {6'h00, 6'h00};
          1:       return {6'h00, 6'h20};
          default: return {6'h00, 6'h25};
        endcase
      end
    endcase
  endfunction

  // Expected per-cycle trace of one instruction, phase by phase.
  function automatic void build(input int kind, input logic z, input int fw, input int dw);
    int alu, src, ext, rd;
    logic [20:0] ma_f;
    exp_ret = 0;
    alu = 0; src = 0; ext = 0;
    if (!push_mem(ST_FETCH, fw, mk(0,0,1,0,0,0,0,0,0,0,0,0,0), mk(1,1,1,0,0,0,0,0,0,0,0,0,0)))
      return;
    if (kind == K_ILLOP || kind == K_ILLFN) begin
      push(ST_DCD, rnd_bit(), mk(0,0,0,0,0,0,0,0,0,0,0,1,0));
      return;
    end
    push(ST_DCD, rnd_bit(), '0);
    ma_f = mk(0,0,0,0,0,0,0,0,1,1,0,0,0);
    exp_ret = 1;
    case (kind)
      K_LW: begin
        push(ST_MA, rnd_bit(), ma_f);
        if (push_mem(ST_MRD, dw, ma_f | mk(0,0,1,0,0,0,0,0,0,0,0,0,0),
                     ma_f | mk(0,0,1,0,0,0,0,0,0,0,0,0,0)))
          push(ST_MWB, rnd_bit(), mk(0,0,0,0,1,0,0,1,0,0,0,0,0));
        else
          exp_ret = 0;
      end
      K_SW: begin
        push(ST_MA, rnd_bit(), ma_f);
        if (!push_mem(ST_MWR, dw, ma_f | mk(0,0,0,1,0,0,0,0,0,0,0,0,0),
                      ma_f | mk(0,0,0,1,0,0,0,0,0,0,0,0,0)))
          exp_ret = 0;
      end
      K_BEQ: push(ST_BR,  rnd_bit(), mk(int'(z),0,0,0,0,1,0,0,0,0,1,0,0));
      K_J:   push(ST_JMP, rnd_bit(), mk(1,0,0,0,0,3,0,0,0,0,0,0,0));
      K_JAL: push(ST_JAL, rnd_bit(), mk(1,0,0,0,1,2,2,2,0,0,0,0,0));
      K_JR:  push(ST_JR,  rnd_bit(), mk(1,0,0,0,0,4,0,0,0,0,4,0,0));
      default: begin
        case (kind)
          K_SUBU:  alu = 1;
          K_SLT:   alu = 6;
          K_ORI:   begin alu = 2; src = 1; ext = 0; end
          K_LUI:   begin alu = 3; src = 1; ext = 2; end
          K_ADDI:  begin alu = 5; src = 1; ext = 1; end
          K_ADDIU: begin alu = 0; src = 1; ext = 1; end
          default: alu = 0;
        endcase
        rd = (kind <= K_SLT) ? 1 : 0;
        push(ST_EXE, rnd_bit(), mk(0,0,0,0,0,0,0,0,ext,src,alu,0,0));
        push(ST_AWB, rnd_bit(), mk(0,0,0,0,1,0,rd,0,ext,src,alu,0,0));
      end
    endcase
  endfunction

  task automatic run_txn(input int kind, input logic z, input int fw, input int dw);
    logic [11:0] ins;
    cyc_t        c;
    int          n;
    exp_q.delete();
    build(kind, z, fw, dw);
    n = exp_q.size();
    ins = enc(kind);
    opcode = ins[11:6];
    funct = ins[5:0];
    zero = z;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      mem_ready = c.rdy;
      @(negedge clk);
      check_val({kname[kind], "_state"}, 32'(state), 32'(c.st));
      check_val({kname[kind], "_outs"}, 32'(outs), 32'(c.o));
      @(posedge clk);
      #1;
    end
`ifdef MC_CTRL_PERF_EN
    exp_cyc_total += n;
    exp_ret_total += exp_ret;
    check_val({kname[kind], "_cyc_cnt"}, cyc_cnt, 32'(exp_cyc_total));
    check_val({kname[kind], "_ret_cnt"}, ret_cnt, 32'(exp_ret_total));
`endif
    txn_cnt++;
    $display("txn %0d %s op=%02h fn=%02h zero=%0d fw=%0d dw=%0d cycles=%0d",
             txn_cnt, kname[kind], ins[11:6], ins[5:0], z, fw, dw, n);
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = 6'h00;
    funct = 6'h00;
    zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("rst_state", 32'(state), 32'd0);
      check_val("rst_outs", 32'(outs), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_txn(K_ADDU, 1'b0, 0, 0);
    run_txn(K_LW, 1'b0, 0, 3);
    run_txn(K_BEQ, 1'b1, 0, 0);
    run_txn(K_BEQ, 1'b0, 0, 0);
    run_txn(K_JAL, 1'b0, 0, 0);
    run_txn(K_ILLOP, 1'b0, 0, 0);
    run_txn(K_SW, 1'b0, 0, 1000);
    run_txn(K_LW, 1'b0, 2, 1000);
    run_txn(K_J, 1'b0, 1000, 0);
    run_txn(K_SW, 1'b0, 3, 3);

    for (int t = 0; t < 200; t++) begin
      int kind, fw, dw;
      kind = $urandom_range(0, 14);
      fw = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 6) : 0;
      dw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 0;
      run_txn(kind, rnd_bit(), fw, dw);
    end

    // Abort an LW in MRD with reset: nothing may be written, machine restarts in FETCH.
    opcode = 6'h23;
    funct = 6'h00;
    mem_ready = 1'b1;
    @(negedge clk);
    check_val("abort_fetch_state", 32'(state), 32'(ST_FETCH));
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("abort_dcd_state", 32'(state), 32'(ST_DCD));
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("abort_ma_state", 32'(state), 32'(ST_MA));
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_val("abort_rst_state", 32'(state), 32'd0);
    check_val("abort_rst_outs", 32'(outs), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("abort_after_state", 32'(state), 32'(ST_FETCH));
    check_val("abort_after_outs", 32'(outs), 32'(mk(0,0,1,0,0,0,0,0,0,0,0,0,0)));
`ifdef MC_CTRL_PERF_EN
    check_val("abort_ret_cnt", ret_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
